// File: rtl/xcorr_pkg.sv
// Shared defaults, width helpers and FSM state type for the
// mic-pair cross-correlation lag estimator.
package xcorr_pkg;

   localparam int XC_SAMPLE_W  = 16;
   localparam int XC_LAG_N     = 64;
   localparam int XC_CENTER    = 30;
   localparam int XC_FRAME_LEN = 1024;

   function automatic int lag_w(input int n);
      return $clog2(n);
   endfunction

   // Full-precision product plus headroom for a whole frame of sums.
   function automatic int acc_w(input int sw, input int fl);
      return 2 * sw + $clog2(fl);
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      SEARCH,
      OUTPUT
   } xc_state_t;

endpackage

// File: rtl/xcorr_argmax.sv
// Serial signed max tracker: one value/index per valid cycle, start opens
// a new scan. Ports: clk, rst, start, valid, value, index -> max_val, max_idx.
module xcorr_argmax
   import xcorr_pkg::*;
#(
   parameter int VAL_W = 42,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             valid,
   input  logic [VAL_W-1:0] value,
   input  logic [IDX_W-1:0] index,
   output logic [VAL_W-1:0] max_val,
   output logic [IDX_W-1:0] max_idx
);

   localparam logic [VAL_W-1:0] MOST_NEG = {1'b1, {(VAL_W-1){1'b0}}};

   logic [VAL_W-1:0] base_val;
   logic [IDX_W-1:0] base_idx;
   logic             take;

   // A new scan compares against the most negative value, not the old max.
   assign base_val = start ? MOST_NEG : max_val;
   assign base_idx = start ? '0 : max_idx;
   // Strictly greater: on ties the earlier (lower) index is kept.
   assign take     = $signed(value) > $signed(base_val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_val <= '0;
         max_idx <= '0;
      end else if (valid) begin
         max_val <= take ? value : base_val;
         max_idx <= take ? index : base_idx;
      end
   end

endmodule

// File: rtl/xcorr_lag_estimator.sv
// Time-multiplexed cross-correlation of one mic pair; reports the lag bin of
// the peak. Ports: clk, rst, sync_clr, sample_* handshake in, lag_*/peak_out.
module xcorr_lag_estimator
   import xcorr_pkg::*;
#(
   parameter int  SAMPLE_W  = XC_SAMPLE_W,
   parameter int  LAG_N     = XC_LAG_N,
   parameter int  CENTER    = XC_CENTER,
   parameter int  FRAME_LEN = XC_FRAME_LEN,
   localparam int LAG_W     = lag_w(LAG_N),
   localparam int ACC_W     = acc_w(SAMPLE_W, FRAME_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sync_clr,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [SAMPLE_W-1:0] sample_a,
   input  logic [SAMPLE_W-1:0] sample_b,
   output logic [LAG_W-1:0]    lag_out,
   output logic                lag_valid,
   output logic [ACC_W-1:0]    peak_out
);

   localparam int CNT_W = $clog2(FRAME_LEN) + 1;
   localparam int PRD_W = 2 * SAMPLE_W;
   localparam logic [LAG_W-1:0] K_LAST  = LAG_W'(LAG_N - 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FRAME_LEN);

   xc_state_t state, state_n;

   logic signed [SAMPLE_W-1:0] a_dly [LAG_N];
   logic signed [SAMPLE_W-1:0] b_dly [CENTER+1];
   logic signed [ACC_W-1:0]    acc   [LAG_N];

   logic [CNT_W-1:0]        cnt;
   logic [LAG_W-1:0]        k;
   logic                    xfer;
   logic                    k_end;
   logic                    frame_end;
   logic signed [PRD_W-1:0] prod;
   logic signed [ACC_W-1:0] prod_x;
   logic                    srch;
   logic [ACC_W-1:0]        max_val;
   logic [LAG_W-1:0]        max_idx;

   assign sample_ready = (state == IDLE) && !sync_clr && !rst;
   assign xfer         = sample_valid && sample_ready;
   assign k_end        = (k == K_LAST);
   assign frame_end    = (cnt == CNT_END);
   assign srch         = (state == SEARCH);

   assign prod   = a_dly[k] * b_dly[CENTER];
   assign prod_x = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (xfer) state_n = MAC;
         MAC:     if (k_end) state_n = frame_end ? SEARCH : IDLE;
         SEARCH:  if (k_end) state_n = OUTPUT;
         OUTPUT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (sync_clr) state_n = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAG_N; i++) begin
            a_dly[i] <= '0;
            acc[i]   <= '0;
         end
         for (int i = 0; i <= CENTER; i++) b_dly[i] <= '0;
         cnt       <= '0;
         k         <= '0;
         lag_out   <= LAG_W'(CENTER);
         peak_out  <= '0;
         lag_valid <= 1'b0;
      end else begin
         lag_valid <= 1'b0;
         if (sync_clr) begin
            // Abort the frame but keep the sample history.
            cnt <= '0;
            k   <= '0;
            for (int i = 0; i < LAG_N; i++) acc[i] <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (xfer) begin
                     a_dly[0] <= sample_a;
                     b_dly[0] <= sample_b;
                     for (int i = 1; i < LAG_N; i++) a_dly[i] <= a_dly[i-1];
                     for (int i = 1; i <= CENTER; i++) b_dly[i] <= b_dly[i-1];
                     cnt <= cnt + 1'b1;
                     k   <= '0;
                  end
               end
               MAC: begin
                  acc[k] <= acc[k] + prod_x;
                  k      <= k_end ? '0 : k + 1'b1;
                  if (k_end && frame_end) cnt <= '0;
               end
               SEARCH: begin
                  // Read-and-clear readies the bins for the next frame.
                  acc[k] <= '0;
                  k      <= k_end ? '0 : k + 1'b1;
               end
               OUTPUT: begin
                  lag_out   <= max_idx;
                  peak_out  <= max_val;
                  lag_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   xcorr_argmax #(
      .VAL_W(ACC_W),
      .IDX_W(LAG_W)
   ) u_argmax (
      .clk    (clk),
      .rst    (rst),
      .start  (srch && (k == '0)),
      .valid  (srch),
      .value  (acc[k]),
      .index  (k),
      .max_val(max_val),
      .max_idx(max_idx)
   );

endmodule

// File: tb/tb_xcorr_lag_estimator.sv
// Directed bench for xcorr_lag_estimator with a 16-sample frame.
// Sign-only pseudo-random samples of magnitude 10000 give exact peaks.
module tb_xcorr_lag_estimator;

   localparam int     FL = 16;
   localparam int     AW = 36;
   localparam longint PK = 64'sd1600000000;

   logic          clk = 1'b0;
   logic          rst;
   logic          sync_clr;
   logic          sample_valid;
   logic          sample_ready;
   logic [15:0]   sample_a;
   logic [15:0]   sample_b;
   logic [5:0]    lag_out;
   logic          lag_valid;
   logic [AW-1:0] peak_out;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int n_acc = 0;
   int n_pulse = 0;
   int last_acc = 0;
   int pulse_t = 0;
   int acc_t[$];
   int seq[1024];
   int gi = 0;

   xcorr_lag_estimator #(.FRAME_LEN(FL)) dut (
      .clk         (clk),
      .rst         (rst),
      .sync_clr    (sync_clr),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .sample_a    (sample_a),
      .sample_b    (sample_b),
      .lag_out     (lag_out),
      .lag_valid   (lag_valid),
      .peak_out    (peak_out)
   );

   always #5 clk = ~clk;

   // Accept times are posedge numbers; a pulse seen here rose one edge earlier.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sample_valid && sample_ready) begin
         n_acc    <= n_acc + 1;
         last_acc <= cyc + 1;
         acc_t.push_back(cyc + 1);
      end
      if (lag_valid) begin
         n_pulse <= n_pulse + 1;
         pulse_t <= cyc;
      end
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b);
      int n0 = n_acc;
      int t = 0;
      sample_a     = a;
      sample_b     = b;
      sample_valid = 1'b1;
      while (n_acc == n0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      sample_valid = 1'b0;
      chk("accept", n_acc - n0, 1);
   endtask

   // b[n] = a[n-d]; zero mode sends silence on both mics.
   task automatic feed(input int n, input int d, input bit zero);
      logic [15:0] av, bv;
      for (int i = 0; i < n; i++) begin
         av = zero ? 16'd0 : 16'(seq[gi]);
         bv = (zero || gi - d < 0) ? 16'd0 : 16'(seq[gi-d]);
         send(av, bv);
         gi++;
      end
   endtask

   task automatic pulse_clr();
      sync_clr = 1'b1;
      tick(1);
      sync_clr = 1'b0;
   endtask

   task automatic wait_pulse(input string tag);
      int n0 = n_pulse;
      int t = 0;
      while (n_pulse == n0 && t < 400) begin
         tick(1);
         t++;
      end
      chk({tag, "_seen"}, n_pulse - n0, 1);
      chk({tag, "_lat"}, pulse_t - last_acc, 129);
      tick(3);
      chk({tag, "_single"}, n_pulse - n0, 1);
   endtask

   task automatic run_case(input int d, input int exp_lag, input string tag);
      feed(40, d, 1'b0);
      pulse_clr();
      feed(FL, d, 1'b0);
      wait_pulse(tag);
      chk({tag, "_lag"}, longint'(lag_out), exp_lag);
      chk({tag, "_peak"}, longint'($signed(peak_out)), PK);
   endtask

   initial begin
      logic [15:0] l;
      int          n0;
      int          t;
      l            = 16'hACE1;
      rst          = 1'b1;
      sync_clr     = 1'b0;
      sample_valid = 1'b0;
      sample_a     = '0;
      sample_b     = '0;
      for (int i = 0; i < 1024; i++) begin
         l      = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         seq[i] = l[0] ? 10000 : -10000;
      end

      tick(2);
      #1;
      chk("rst_lag", longint'(lag_out), 30);
      chk("rst_peak", longint'($signed(peak_out)), 0);
      chk("rst_valid", longint'(lag_valid), 0);
      chk("rst_ready", longint'(sample_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", longint'(sample_ready), 1);

      // Continuous valid: one accept per LAG_N+1 cycles.
      acc_t.delete();
      sample_a     = 16'd100;
      sample_b     = 16'd200;
      sample_valid = 1'b1;
      n0 = n_acc;
      t  = 0;
      while (n_acc < n0 + 4 && t < 600) begin
         @(negedge clk);
         t++;
      end
      sample_valid = 1'b0;
      chk("tp_count", n_acc - n0, 4);
      for (int i = 1; i < 4; i++)
         chk("tp_gap", acc_t[i] - acc_t[i-1], 65);
      tick(1);
      chk("busy_ready", longint'(sample_ready), 0);

      // Abort after 7 accepts: the frame restarts from zero.
      pulse_clr();
      feed(7, 2, 1'b0);
      pulse_clr();
      feed(FL - 1, 2, 1'b0);
      n0 = n_pulse;
      tick(200);
      chk("clr_no_pulse", n_pulse - n0, 0);
      feed(1, 2, 1'b0);
      wait_pulse("clr_frame");

      run_case(3, 33, "lag_p3");
      run_case(-5, 25, "lag_m5");
      run_case(0, 30, "lag_0");

      // Silence: every bin ties at zero, lowest index wins.
      feed(40, 0, 1'b1);
      pulse_clr();
      feed(FL, 0, 1'b1);
      wait_pulse("zero");
      chk("zero_lag", longint'(lag_out), 0);
      chk("zero_peak", longint'($signed(peak_out)), 0);

      // Three frames back to back; the third only matches if bins cleared.
      feed(3 * FL, 1, 1'b0);
      wait_pulse("lag_p1");
      chk("lag_p1_lag", longint'(lag_out), 31);
      chk("lag_p1_peak", longint'($signed(peak_out)), PK);

      // sync_clr while in OUTPUT: pulse and update suppressed.
      pulse_clr();
      feed(FL, 4, 1'b0);
      n0 = n_pulse;
      t  = 0;
      while (cyc != last_acc + 128 && t < 300) begin
         tick(1);
         t++;
      end
      chk("out_clr_reach", cyc - last_acc, 128);
      pulse_clr();
      tick(150);
      chk("out_clr_no_pulse", n_pulse - n0, 0);
      chk("out_clr_lag", longint'(lag_out), 31);
      chk("out_clr_peak", longint'($signed(peak_out)), PK);
      chk("out_clr_ready", longint'(sample_ready), 1);

      // Reset mid-MAC discards the partial frame and the history.
      feed(1, 0, 1'b0);
      tick(10);
      rst = 1'b1;
      #1;
      chk("mid_rst_lag", longint'(lag_out), 30);
      chk("mid_rst_peak", longint'($signed(peak_out)), 0);
      chk("mid_rst_valid", longint'(lag_valid), 0);
      chk("mid_rst_ready", longint'(sample_ready), 0);
      tick(2);
      rst = 1'b0;
      #1;
      chk("mid_rst_ready_rel", longint'(sample_ready), 1);
      feed(FL - 1, 0, 1'b0);
      n0 = n_pulse;
      tick(200);
      chk("mid_rst_no_pulse", n_pulse - n0, 0);
      feed(1, 0, 1'b0);
      wait_pulse("post_rst");
      chk("post_rst_lag", longint'(lag_out), 0);
      chk("post_rst_peak", longint'($signed(peak_out)), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
